// File: rtl/dot_product_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_accumulator_pkg
// Description : Default sizing constants shared by the dot-product block and
//               its multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package dot_product_accumulator_pkg;

   // Default operand width of the multiplier/accumulator pair
   localparam int C_DEFAULT_WIDTH       = 6;
   // Default element counter width
   localparam int C_DEFAULT_COUNT_WIDTH = 8;

endpackage : dot_product_accumulator_pkg
`default_nettype wire

// File: rtl/slow_multiplication.sv
`default_nettype none
// ============================================================================
// Module      : slow_multiplication
// Description : Unsigned WIDTH x WIDTH multiplier with WIDTH-1 register
//               stages between the operands and the product. The whole
//               pipeline advances only while enable is high.
// Revision    : 1.0 - initial release
// ============================================================================
module slow_multiplication
   import dot_product_accumulator_pkg::*;
#(
   parameter int WIDTH = C_DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 enable,
   input  logic [WIDTH-1:0]     in_1,
   input  logic [WIDTH-1:0]     in_2,
   output logic [2*WIDTH-1:0]   out
);

   localparam int STAGES = WIDTH - 1;

   logic [2*WIDTH-1:0] r_p [STAGES];
   logic [2*WIDTH-1:0] w_prod;

   // Zero-extend both operands so the product is formed at full width
   assign w_prod = {{WIDTH{1'b0}}, in_1} * {{WIDTH{1'b0}}, in_2};

   // First stage registers the freshly formed product
   always_ff @(posedge clk) begin
      if (enable) begin
         r_p[0] <= w_prod;
      end
   end

   // Remaining stages carry the product forward one per enabled edge
   for (genvar k = 1; k < STAGES; k++) begin : g_stage
      always_ff @(posedge clk) begin
         if (enable) begin
            r_p[k] <= r_p[k-1];
         end
      end
   end

   assign out = r_p[STAGES-1];

endmodule : slow_multiplication
`default_nettype wire

// File: rtl/dot_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_accumulator
// Description : Streams operand pairs through slow_multiplication and sums
//               the products of each vector into a saturating accumulator,
//               emitting one dot product (with element count and overflow
//               flag) per vector.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_accumulator
   import dot_product_accumulator_pkg::*;
#(
   parameter int WIDTH        = C_DEFAULT_WIDTH,
   parameter int MULT_LATENCY = WIDTH - 1,
   parameter int ACC_WIDTH    = 2*WIDTH + 4,
   parameter int COUNT_WIDTH  = C_DEFAULT_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   in_valid,
   input  logic                   in_first,
   input  logic                   in_last,
   input  logic [WIDTH-1:0]       in_1,
   input  logic [WIDTH-1:0]       in_2,
   output logic [ACC_WIDTH-1:0]   out,
   output logic [COUNT_WIDTH-1:0] out_count,
   output logic                   overflow,
   output logic                   out_valid
);

   // Accepted element, registered once before it enters the multiplier
   logic                    r_in_valid;
   logic                    r_in_first;
   logic                    r_in_last;
   logic [WIDTH-1:0]        r_in_a;
   logic [WIDTH-1:0]        r_in_b;

   // Sideband flags travelling in lockstep with the multiplier pipeline
   logic [MULT_LATENCY-1:0] r_sb_valid;
   logic [MULT_LATENCY-1:0] r_sb_first;
   logic [MULT_LATENCY-1:0] r_sb_last;
   logic [MULT_LATENCY-1:0] w_sb_valid_next;
   logic [MULT_LATENCY-1:0] w_sb_first_next;
   logic [MULT_LATENCY-1:0] w_sb_last_next;

   logic                    w_d_valid;
   logic                    w_d_first;
   logic                    w_d_last;

   logic [2*WIDTH-1:0]      w_p;
   logic [ACC_WIDTH-1:0]    w_p_ext;
   logic [ACC_WIDTH:0]      w_sum;

   logic [ACC_WIDTH-1:0]    r_acc;
   logic [COUNT_WIDTH-1:0]  r_count;
   logic                    r_sat;
   logic [ACC_WIDTH-1:0]    w_acc_next;
   logic [COUNT_WIDTH-1:0]  w_count_next;
   logic                    w_sat_next;

   logic [ACC_WIDTH-1:0]    r_out;
   logic [COUNT_WIDTH-1:0]  r_out_count;
   logic                    r_overflow;
   logic                    r_out_valid;

   slow_multiplication #(
      .WIDTH (WIDTH)
   ) u_mult (
      .clk    (clk),
      .enable (enable),
      .in_1   (r_in_a),
      .in_2   (r_in_b),
      .out    (w_p)
   );

   // A single-stage pipe has no older entries to shift along
   if (MULT_LATENCY > 1) begin : g_sb_deep
      assign w_sb_valid_next = {r_sb_valid[MULT_LATENCY-2:0], r_in_valid};
      assign w_sb_first_next = {r_sb_first[MULT_LATENCY-2:0], r_in_first};
      assign w_sb_last_next  = {r_sb_last[MULT_LATENCY-2:0],  r_in_last};
   end else begin : g_sb_single
      assign w_sb_valid_next = r_in_valid;
      assign w_sb_first_next = r_in_first;
      assign w_sb_last_next  = r_in_last;
   end

   assign w_d_valid = r_sb_valid[MULT_LATENCY-1];
   assign w_d_first = r_sb_first[MULT_LATENCY-1];
   assign w_d_last  = r_sb_last[MULT_LATENCY-1];

   // Capture the element and shift its flags alongside the multiplier
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_valid <= 1'b0;
         r_in_first <= 1'b0;
         r_in_last  <= 1'b0;
         r_in_a     <= '0;
         r_in_b     <= '0;
         r_sb_valid <= '0;
         r_sb_first <= '0;
         r_sb_last  <= '0;
      end else if (enable) begin
         r_in_valid <= in_valid;
         r_in_first <= in_valid & in_first;
         r_in_last  <= in_valid & in_last;
         r_in_a     <= in_1;
         r_in_b     <= in_2;
         r_sb_valid <= w_sb_valid_next;
         r_sb_first <= w_sb_first_next;
         r_sb_last  <= w_sb_last_next;
      end
   end

   // The carry out of a one-bit-wider add is the saturation signal
   assign w_p_ext = ACC_WIDTH'(w_p);
   assign w_sum   = {1'b0, r_acc} + {1'b0, w_p_ext};

   // Next accumulator/count/saturation for the element leaving the pipe
   always_comb begin
      w_acc_next   = r_acc;
      w_count_next = r_count;
      w_sat_next   = r_sat;
      if (w_d_valid) begin
         if (w_d_first) begin
            w_acc_next   = w_p_ext;
            w_count_next = COUNT_WIDTH'(1);
            w_sat_next   = 1'b0;
         end else begin
            w_count_next = r_count + COUNT_WIDTH'(1);
            if (w_sum[ACC_WIDTH]) begin
               w_acc_next = '1;
               w_sat_next = 1'b1;
            end else begin
               w_acc_next = w_sum[ACC_WIDTH-1:0];
               w_sat_next = r_sat;
            end
         end
      end
   end

   // Accumulator state; a completed vector leaves it cleared for the next
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc   <= '0;
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (enable) begin
         if (w_d_valid && w_d_last) begin
            r_acc   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
         end else begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_sat   <= w_sat_next;
         end
      end
   end

   // Result registers; the valid strobe lasts one cycle and drops when frozen
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out       <= '0;
         r_out_count <= '0;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (enable && w_d_valid && w_d_last) begin
            r_out       <= w_acc_next;
            r_out_count <= w_count_next;
            r_overflow  <= w_sat_next;
            r_out_valid <= 1'b1;
         end
      end
   end

   assign out       = r_out;
   assign out_count = r_out_count;
   assign overflow  = r_overflow;
   assign out_valid = r_out_valid;

endmodule : dot_product_accumulator
`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_product_accumulator
// Description : Bench for dot_product_accumulator. Two instances (16-bit and
//               12-bit accumulators) receive identical stimulus and are
//               compared against a vector-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_product_accumulator;

   localparam int WIDTH = 6;
   localparam int LAT   = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        in_valid;
   logic        in_first;
   logic        in_last;
   logic [5:0]  in_1;
   logic [5:0]  in_2;

   logic [15:0] out16;
   logic [7:0]  cnt16;
   logic        ovf16;
   logic        vld16;
   logic [11:0] out12;
   logic [7:0]  cnt12;
   logic        ovf12;
   logic        vld12;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dot_product_accumulator #(
      .WIDTH(WIDTH), .MULT_LATENCY(LAT), .ACC_WIDTH(16), .COUNT_WIDTH(8)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
      .in_first(in_first), .in_last(in_last), .in_1(in_1), .in_2(in_2),
      .out(out16), .out_count(cnt16), .overflow(ovf16), .out_valid(vld16)
   );

   dot_product_accumulator #(
      .WIDTH(WIDTH), .MULT_LATENCY(LAT), .ACC_WIDTH(12), .COUNT_WIDTH(8)
   ) dut12 (
      .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
      .in_first(in_first), .in_last(in_last), .in_1(in_1), .in_2(in_2),
      .out(out12), .out_count(cnt12), .overflow(ovf12), .out_valid(vld12)
   );

   // Reference model: vectors are summed as elements are accepted; each
   // finished vector becomes visible after LAT+1 further enabled edges.
   typedef struct {
      int     rem;
      longint v0;
      longint v1;
      int     cnt;
      bit     s0;
      bit     s1;
   } pend_t;

   pend_t  q[$];
   longint m_sum [2];
   bit     m_sat [2];
   int     m_cnt;
   longint m_max [2] = '{65535, 4095};

   longint exp_out [2];
   bit     exp_ovf [2];
   int     exp_cnt;
   bit     exp_vld;

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 2; i++) begin
         m_sum[i]   = 0;
         m_sat[i]   = 1'b0;
         exp_out[i] = 0;
         exp_ovf[i] = 1'b0;
      end
      m_cnt   = 0;
      exp_cnt = 0;
      exp_vld = 1'b0;
   endtask

   task automatic model_edge(input bit v, input bit f, input bit l,
                             input int a, input int b, input bit en);
      pend_t  e;
      longint p;
      exp_vld = 1'b0;
      if (en) begin
         foreach (q[i]) q[i].rem--;
         if (q.size() > 0 && q[0].rem == 0) begin
            e = q.pop_front();
            exp_out[0] = e.v0;
            exp_out[1] = e.v1;
            exp_ovf[0] = e.s0;
            exp_ovf[1] = e.s1;
            exp_cnt    = e.cnt;
            exp_vld    = 1'b1;
         end
         if (v) begin
            p = longint'(a) * longint'(b);
            for (int i = 0; i < 2; i++) begin
               if (f) begin
                  m_sum[i] = p;
                  m_sat[i] = 1'b0;
               end else if (m_sum[i] + p > m_max[i]) begin
                  m_sum[i] = m_max[i];
                  m_sat[i] = 1'b1;
               end else begin
                  m_sum[i] = m_sum[i] + p;
               end
            end
            m_cnt = f ? 1 : m_cnt + 1;
            if (l) begin
               e.rem = LAT + 1;
               e.v0  = m_sum[0];
               e.v1  = m_sum[1];
               e.s0  = m_sat[0];
               e.s1  = m_sat[1];
               e.cnt = m_cnt % 256;
               q.push_back(e);
               m_sum = '{0, 0};
               m_sat = '{1'b0, 1'b0};
               m_cnt = 0;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input longint obs, input longint expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      chk("out_valid16", longint'(vld16), longint'(exp_vld));
      chk("out16",       longint'(out16), exp_out[0]);
      chk("out_count16", longint'(cnt16), longint'(exp_cnt));
      chk("overflow16",  longint'(ovf16), longint'(exp_ovf[0]));
      chk("out_valid12", longint'(vld12), longint'(exp_vld));
      chk("out12",       longint'(out12), exp_out[1]);
      chk("out_count12", longint'(cnt12), longint'(exp_cnt));
      chk("overflow12",  longint'(ovf12), longint'(exp_ovf[1]));
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare
   task automatic step(input bit v, input bit f, input bit l,
                       input int a, input int b, input bit en);
      in_valid = v;
      in_first = f;
      in_last  = l;
      in_1     = 6'(a);
      in_2     = 6'(b);
      enable   = en;
      @(posedge clk);
      #1;
      model_edge(v, f, l, a, b, en);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
   endtask

   initial begin
      reset    = 1'b1;
      enable   = 1'b1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      in_1     = '0;
      in_2     = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      #3;
      reset = 1'b0;

      // Four-element vector: 10 + 120 + 2400 + 100 = 2630
      step(1, 1, 0, 1, 10, 1);
      step(1, 0, 0, 10, 12, 1);
      step(1, 0, 0, 60, 40, 1);
      step(1, 0, 1, 10, 10, 1);
      idle(8);

      // Single-element vector, then a vector with no first flag
      step(1, 1, 1, 63, 63, 1);
      idle(3);
      step(1, 0, 0, 2, 2, 1);
      step(1, 0, 1, 3, 3, 1);
      idle(8);

      // Saturates the 12-bit instance; next single vector is clean
      step(1, 1, 0, 63, 63, 1);
      step(1, 0, 1, 63, 63, 1);
      step(1, 1, 1, 2, 2, 1);
      idle(8);

      // Same vector with a freeze and bubbles
      step(1, 1, 0, 1, 10, 1);
      step(0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 10, 12, 1);
      step(1, 0, 0, 60, 40, 0);
      step(1, 0, 0, 60, 40, 0);
      step(1, 0, 0, 60, 40, 0);
      step(1, 0, 0, 60, 40, 1);
      step(0, 1, 1, 5, 5, 1);
      step(1, 0, 1, 10, 10, 1);
      step(1, 0, 0, 9, 9, 0);
      idle(8);

      // Asynchronous reset in the middle of an open vector
      step(1, 1, 0, 7, 7, 1);
      step(1, 0, 0, 8, 8, 1);
      step(1, 0, 1, 9, 9, 1);
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      #2;
      reset = 1'b0;
      step(1, 1, 0, 2, 3, 1);
      step(1, 0, 1, 4, 5, 1);
      idle(8);

      // Back-to-back completions on consecutive cycles
      step(1, 1, 1, 1, 1, 1);
      step(1, 1, 1, 2, 2, 1);
      idle(8);

      // Randomised traffic: freezes, bubbles, reopened and unopened vectors
      for (int i = 0; i < 500; i++) begin
         step(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 4) == 0,
              int'($urandom % 64), int'($urandom % 64), ($urandom % 6) != 0);
      end
      idle(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_dot_product_accumulator
`default_nettype wire
